// File: rtl/my_stream_pkg.sv
// Shared types for the two-channel packet merger.
// Merge FSM states and source-tag encodings.
package my_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOCK_A,
        LOCK_B
    } merge_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/my_rr_arb2.sv
// Two-request round-robin arbiter.
// Priority flips away from the winner at each packet end.
module my_rr_arb2
    import my_stream_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic pkt_done,
    input  logic done_sel,
    output logic grant
);

    logic prio;

    // priority register: favour the other channel after a packet ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= SEL_A;
        end else if (pkt_done) begin
            prio <= ~done_sel;
        end
    end

    // lone requester wins; contention resolved by prio
    always_comb begin
        grant = prio;
        unique case (1'b1)
            (req_a && !req_b): grant = SEL_A;
            (req_b && !req_a): grant = SEL_B;
            default:           grant = prio;
        endcase
    end

endmodule

// File: rtl/my_stream_merge.sv
// Two-input packet merger with one registered output stage.
// Packets are never interleaved; out_sel tags the source.
module my_stream_merge
    import my_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_sel,
    output logic             out_valid,
    input  logic             out_ready
);

    merge_state_t     state;
    merge_state_t     state_nxt;
    logic             load;
    logic             grant;
    logic             sel;
    logic             xfer;
    logic             pkt_done;
    logic [WIDTH-1:0] cur_data;
    logic             cur_last;

    assign load = !out_valid || out_ready;

    // the mux keeps the unselected channel's data off the output
    assign cur_data = (sel == SEL_B) ? b_data : a_data;
    assign cur_last = (sel == SEL_B) ? b_last : a_last;
    assign xfer     = (a_ready && a_valid) || (b_ready && b_valid);
    assign pkt_done = xfer && cur_last;

    my_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_a    (a_valid),
        .req_b    (b_valid),
        .pkt_done (pkt_done),
        .done_sel (sel),
        .grant    (grant)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // channel select and readys: locked channel only, else arbiter grant
    always_comb begin
        sel     = SEL_A;
        a_ready = 1'b0;
        b_ready = 1'b0;
        unique case (state)
            IDLE: begin
                sel     = grant;
                a_ready = load && a_valid && (grant == SEL_A);
                b_ready = load && b_valid && (grant == SEL_B);
            end
            LOCK_A: begin
                sel     = SEL_A;
                a_ready = load;
            end
            LOCK_B: begin
                sel     = SEL_B;
                b_ready = load;
            end
            default: begin
                sel = SEL_A;
            end
        endcase
    end

    // next state: lock on a non-final beat, release on the last beat
    always_comb begin
        state_nxt = state;
        if (xfer) begin
            if (cur_last) begin
                state_nxt = IDLE;
            end else if (sel == SEL_B) begin
                state_nxt = LOCK_B;
            end else begin
                state_nxt = LOCK_A;
            end
        end else if (state != IDLE && state != LOCK_A
                     && state != LOCK_B) begin
            state_nxt = IDLE;
        end
    end

    // output stage: refill on load; data kept when valid drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= SEL_A;
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= cur_data;
                out_last <= cur_last;
                out_sel  <= sel;
            end
        end
    end

endmodule
